or1200_keccak_cpu: RTL and testbench

Minimal three-stage (ID/EX/WB) OR1200-style integer core slice with a tightly coupled sponge-permutation accelerator reached through l.cust5. It executes l.addi, l.sw (no memory side effect) and l.cust5 sponge ops. The instruction word is driven directly on if_insn; the write-back data bus rf_dataw is the only observable output. Serves as a unit-level vehicle for the keccak custom-instruction datapath.

---
 rtl/or1200_keccak_cpu.sv | 243 ++++++++++++++++++++++++
 tb/tb_or1200_keccak_cpu.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/or1200_keccak_cpu.sv
// or1200_keccak_cpu
//   Three-stage (ID/EX/WB) OR1200-style integer slice with a sponge
//   permutation accelerator reached through l.cust5.
//   Executes l.addi, l.sw (no memory side effect) and the l.cust5
//   start/absorb/end/read ops. Every other opcode behaves as a bubble.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   id/ex/wb_freeze          per-stage hold; a freeze also holds every upstream stage
//   extend_flush, except_flushpipe, du_hwbkpt
//                            turn ID and EX into bubbles; these win over freezes
//   if_insn[31:0]            instruction word sampled into ID
//   abort_mvspr, ex_branch_taken, pc_we, id_pc, ex_pc, wbforw_valid, spr_cs
//                            present for interface compatibility, no effect
//   rf_dataw[31:0]           WB-stage register-file write data (0 for bubbles)
module or1200_keccak_cpu #(
    parameter int ROUNDS = 24,
    parameter int LANES  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_freeze,
    input  logic        ex_freeze,
    input  logic        wb_freeze,
    input  logic        extend_flush,
    input  logic        except_flushpipe,
    input  logic        abort_mvspr,
    input  logic [31:0] if_insn,
    input  logic        ex_branch_taken,
    input  logic        pc_we,
    input  logic [31:0] id_pc,
    input  logic [31:0] ex_pc,
    input  logic        wbforw_valid,
    input  logic        du_hwbkpt,
    input  logic [31:0] spr_cs,
    output logic [31:0] rf_dataw
);
    localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [5:0] OPC_ADDI  = 6'h27;
    localparam logic [5:0] OPC_SW    = 6'h35;
    localparam logic [5:0] OPC_CUST5 = 6'h3C;

    localparam logic [4:0] OP_END    = 5'b00001;
    localparam logic [4:0] OP_ABSORB = 5'b00010;
    localparam logic [4:0] OP_START  = 5'b00100;
    localparam logic [4:0] OP_READ   = 5'b01000;

    // Pipeline registers
    logic        id_vld_q, id_vld_d;
    logic [31:0] id_insn_q, id_insn_d;
    logic        ex_vld_q, ex_vld_d;
    logic [31:0] ex_insn_q, ex_insn_d;
    logic        wb_wen_q, wb_wen_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] rf_dataw_q, rf_dataw_d;

    // Register file
    logic [31:0] gpr_q [32];

    // Sponge state
    logic [LANES-1:0][31:0] s_q, s_d, perm;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic                   busy_q, busy_d;
    logic [RW-1:0]          round_q, round_d;

    logic flush, id_hold, ex_hold, wb_hold;
    logic [5:0]  ex_opc;
    logic [4:0]  ex_rd, ex_ra, ex_op;
    logic [15:0] ex_imm;
    logic [31:0] ex_opa, ex_res;
    logic        ex_wen, sp_commit;

    logic unused_ok;
    assign unused_ok = ^{abort_mvspr, ex_branch_taken, pc_we, id_pc, ex_pc,
                         wbforw_valid, spr_cs};

    assign flush   = extend_flush | except_flushpipe | du_hwbkpt;
    assign wb_hold = wb_freeze;
    assign ex_hold = ex_freeze | wb_hold;
    assign id_hold = id_freeze | ex_hold;

    assign ex_opc = ex_insn_q[31:26];
    assign ex_rd  = ex_insn_q[25:21];
    assign ex_ra  = ex_insn_q[20:16];
    assign ex_imm = ex_insn_q[15:0];
    assign ex_op  = ex_insn_q[4:0];

    assign rf_dataw = rf_dataw_q;

    // Operand A: r0 is hard zero; WB result bypasses the not-yet-written GPR.
    // One bypass level suffices because WB retires into the RF on the next edge.
    always_comb begin
        if (ex_ra == 5'd0)
            ex_opa = '0;
        else if (wb_wen_q && (wb_rd_q == ex_ra))
            ex_opa = rf_dataw_q;
        else
            ex_opa = gpr_q[ex_ra];
    end

    always_comb begin
        ex_wen = 1'b0;
        ex_res = '0;
        if (ex_vld_q) begin
            case (ex_opc)
                OPC_ADDI: begin
                    ex_wen = 1'b1;
                    ex_res = ex_opa + {{16{ex_imm[15]}}, ex_imm};
                end
                OPC_SW: ex_wen = 1'b0;
                OPC_CUST5: begin
                    if (ex_op == OP_READ) begin
                        ex_wen = 1'b1;
                        ex_res = s_q[ex_insn_q[5 +: PW]];
                    end
                end
                default: ex_wen = 1'b0;
            endcase
        end
    end

    // Sponge ops only act when the insn really moves EX->WB (not held, not
    // killed by a flush); !ex_hold also covers wb_freeze.
    assign sp_commit = ex_vld_q && (ex_opc == OPC_CUST5) && !ex_hold && !flush && !busy_q;

    always_comb begin
        id_vld_d  = id_vld_q;
        id_insn_d = id_insn_q;
        if (flush) begin
            id_vld_d  = 1'b0;
            id_insn_d = '0;
        end else if (!id_hold) begin
            id_vld_d  = 1'b1;
            id_insn_d = if_insn;
        end

        ex_vld_d  = ex_vld_q;
        ex_insn_d = ex_insn_q;
        if (flush || (!ex_hold && id_hold)) begin
            ex_vld_d  = 1'b0;
            ex_insn_d = '0;
        end else if (!ex_hold) begin
            ex_vld_d  = id_vld_q;
            ex_insn_d = id_insn_q;
        end

        wb_wen_d   = wb_wen_q;
        wb_rd_d    = wb_rd_q;
        rf_dataw_d = rf_dataw_q;
        if (!wb_hold) begin
            if (ex_hold || flush) begin
                wb_wen_d   = 1'b0;
                wb_rd_d    = '0;
                rf_dataw_d = '0;
            end else begin
                wb_wen_d   = ex_wen && (ex_rd != 5'd0);
                wb_rd_d    = ex_wen ? ex_rd : 5'd0;
                rf_dataw_d = ex_res;
            end
        end
    end

    // One permutation round: every lane mixes in its three successors.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [31:0] nxt1;
        assign nxt1    = s_q[(i + 1) % LANES];
        assign perm[i] = s_q[i] ^ {nxt1[30:0], nxt1[31]}
                       ^ (~s_q[(i + 2) % LANES] & s_q[(i + 3) % LANES]);
    end

    always_comb begin
        s_d     = s_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        round_d = round_q;
        if (busy_q) begin
            s_d     = perm;
            s_d[0]  = perm[0] ^ (32'h1 << round_q);
            round_d = round_q + RW'(1);
            if (round_q == RW'(ROUNDS - 1)) begin
                busy_d  = 1'b0;
                round_d = '0;
            end
        end else if (sp_commit) begin
            case (ex_op)
                OP_START: begin
                    s_d    = '0;
                    s_d[0] = ex_opa;
                    ptr_d  = PW'(1);
                end
                OP_ABSORB: begin
                    s_d[ptr_q] = s_q[ptr_q] ^ ex_opa;
                    ptr_d      = ptr_q + PW'(1);
                end
                OP_END: begin
                    s_d[ptr_q] = s_q[ptr_q] ^ ex_opa;
                    busy_d     = 1'b1;
                    round_d    = '0;
                end
                default: s_d = s_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_vld_q   <= 1'b0;
            id_insn_q  <= '0;
            ex_vld_q   <= 1'b0;
            ex_insn_q  <= '0;
            wb_wen_q   <= 1'b0;
            wb_rd_q    <= '0;
            rf_dataw_q <= '0;
            s_q        <= '0;
            ptr_q      <= '0;
            busy_q     <= 1'b0;
            round_q    <= '0;
        end else begin
            id_vld_q   <= id_vld_d;
            id_insn_q  <= id_insn_d;
            ex_vld_q   <= ex_vld_d;
            ex_insn_q  <= ex_insn_d;
            wb_wen_q   <= wb_wen_d;
            wb_rd_q    <= wb_rd_d;
            rf_dataw_q <= rf_dataw_d;
            s_q        <= s_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            round_q    <= round_d;
        end
    end

    // A held WB stage does not retire, so each insn writes exactly once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) gpr_q[i] <= '0;
        end else if (wb_wen_q && !wb_freeze) begin
            gpr_q[wb_rd_q] <= rf_dataw_q;
        end
    end
endmodule

// File: tb/tb_or1200_keccak_cpu.sv
module tb_or1200_keccak_cpu;
    logic        clk = 1'b0;
    logic        rst;
    logic        id_freeze, ex_freeze, wb_freeze;
    logic        extend_flush, except_flushpipe, abort_mvspr;
    logic [31:0] if_insn;
    logic        ex_branch_taken, pc_we, wbforw_valid, du_hwbkpt;
    logic [31:0] id_pc, ex_pc, spr_cs;
    logic [31:0] rf_dataw;

    always #5 clk = ~clk;

    or1200_keccak_cpu dut (
        .clk(clk), .rst(rst),
        .id_freeze(id_freeze), .ex_freeze(ex_freeze), .wb_freeze(wb_freeze),
        .extend_flush(extend_flush), .except_flushpipe(except_flushpipe),
        .abort_mvspr(abort_mvspr), .if_insn(if_insn),
        .ex_branch_taken(ex_branch_taken), .pc_we(pc_we),
        .id_pc(id_pc), .ex_pc(ex_pc), .wbforw_valid(wbforw_valid),
        .du_hwbkpt(du_hwbkpt), .spr_cs(spr_cs), .rf_dataw(rf_dataw)
    );

    typedef logic [15:0][31:0] st_t;
    typedef struct { logic [31:0] insn; logic [31:0] exp; string name; } vec_t;
    typedef struct { int due; logic [31:0] exp; string name; } sb_t;

    localparam logic [4:0] OP_END = 5'b00001, OP_ABSORB = 5'b00010;
    localparam logic [4:0] OP_START = 5'b00100, OP_READ = 5'b01000;

    sb_t  sb[$];
    sb_t  mon_e;
    vec_t vt[$];
    st_t  after_r [25];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard: compare the head entry when its WB cycle arrives.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            if (mon_e.due != cyc) check({mon_e.name, " late"}, 32'(mon_e.due), 32'(cyc));
            else                  check(mon_e.name, rf_dataw, mon_e.exp);
        end
    end

    function automatic logic [31:0] addi(input int rd, input int ra, input logic [15:0] imm);
        return {6'h27, 5'(rd), 5'(ra), imm};
    endfunction

    function automatic logic [31:0] cust5(input int rd, input int ra, input int limm, input logic [4:0] op);
        return {6'h3C, 5'(rd), 5'(ra), 5'd0, 6'(limm), op};
    endfunction

    function automatic vec_t V(input logic [31:0] i, input logic [31:0] e, input string n);
        vec_t v;
        v.insn = i; v.exp = e; v.name = n;
        return v;
    endfunction

    function automatic st_t rnd(input st_t s, input int r);
        st_t n;
        logic [31:0] x;
        for (int i = 0; i < 16; i++) begin
            x = s[(i + 1) % 16];
            n[i] = s[i] ^ {x[30:0], x[31]} ^ (~s[(i + 2) % 16] & s[(i + 3) % 16]);
        end
        n[0] = n[0] ^ (32'h1 << r);
        return n;
    endfunction

    // Called right after a negedge: insn is captured at the next edge and
    // lands in WB two edges later.
    task automatic issue(input logic [31:0] insn, input logic [31:0] exp, input string nm);
        sb_t e;
        e.due = cyc + 3; e.exp = exp; e.name = nm;
        sb.push_back(e);
        if_insn = insn;
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        if_insn = '0;
        while (sb.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            check("drain timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        id_freeze = 0; ex_freeze = 0; wb_freeze = 0;
        extend_flush = 0; except_flushpipe = 0; abort_mvspr = 0;
        ex_branch_taken = 0; pc_we = 0; wbforw_valid = 0; du_hwbkpt = 0;
        id_pc = '0; ex_pc = '0; spr_cs = '0; if_insn = '0;

        after_r[0] = '0;
        after_r[0][1] = 32'h1;
        for (int k = 0; k < 24; k++) after_r[k + 1] = rnd(after_r[k], k);

        vt.push_back(V(addi(1, 1, 16'h0000), 32'h0,        "addi r1"));
        vt.push_back(V(addi(2, 1, 16'h0001), 32'h1,        "addi r2"));
        vt.push_back(V(addi(3, 1, 16'h0002), 32'h2,        "addi r3"));
        vt.push_back(V({6'h35, 5'd3, 5'd1, 16'h0004}, 32'h0, "sw"));
        vt.push_back(V(addi(5, 0, 16'hFFFF), 32'hFFFFFFFF, "sext"));
        vt.push_back(V(addi(5, 5, 16'h0001), 32'h0,        "bypass wrap"));
        vt.push_back(V(addi(6, 2, 16'h0005), 32'h6,        "gpr r2"));
        vt.push_back(V(addi(7, 3, 16'h7FFF), 32'h8001,     "r3 kept after sw"));
        vt.push_back(V(addi(8, 7, 16'h8000), 32'h1,        "neg imm wrap"));
        vt.push_back(V(addi(0, 3, 16'h0005), 32'h7,        "addi r0 data"));
        vt.push_back(V(addi(9, 0, 16'h0003), 32'h3,        "r0 reads zero"));
        vt.push_back(V(32'h0,                32'h0,        "zero insn"));
        vt.push_back(V(cust5(11, 1, 0, 5'b10000), 32'h0,   "cust5 bad op"));
        vt.push_back(V(addi(12, 8, 16'h0000), 32'h1,       "gpr r8"));
        vt.push_back(V(addi(13, 1, 16'h0000), 32'h0,       "gpr r1"));
        vt.push_back(V(addi(14, 2, 16'h0000), 32'h1,       "gpr r2b"));
        vt.push_back(V(addi(15, 3, 16'h0000), 32'h2,       "gpr r3"));
        vt.push_back(V(addi(16, 16, 16'h0003), 32'h3,      "chain 1"));
        vt.push_back(V(addi(16, 16, 16'h0003), 32'h6,      "chain 2"));
        vt.push_back(V(addi(16, 16, 16'h0003), 32'h9,      "chain 3"));

        repeat (2) @(negedge clk);
        check("reset rf_dataw", rf_dataw, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        foreach (vt[i]) issue(vt[i].insn, vt[i].exp, vt[i].name);

        // Sponge: s[1] = 1 after start/absorb/end, then 24 rounds.
        issue(cust5(0, 1, 0, OP_START),  32'h0, "start");
        issue(cust5(0, 2, 0, OP_ABSORB), 32'h0, "absorb");
        issue(cust5(0, 4, 0, OP_END),    32'h0, "end");
        issue(cust5(20, 0, 1, OP_READ),  after_r[0][1], "read busy r0");
        issue(cust5(21, 0, 0, OP_READ),  after_r[1][0], "read busy r1");
        issue(cust5(0, 2, 0, OP_START),  32'h0, "start while busy");
        repeat (50) issue(32'h0, 32'h0, "idle");
        for (int idx = 15; idx >= 0; idx--) issue(cust5(22, 0, idx, OP_READ), after_r[24][idx], "read final");
        issue(addi(23, 22, 16'h0000), after_r[24][0], "read wrote rd");
        drain();

        // ex_freeze for 3 cycles with A in EX, B in ID, C on if_insn.
        if_insn = addi(17, 17, 16'h1); @(negedge clk);
        if_insn = addi(17, 17, 16'h1); @(negedge clk);
        if_insn = addi(18, 17, 16'h0);
        ex_freeze = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("freeze bubble", rf_dataw, 32'h0);
        end
        ex_freeze = 1'b0;
        @(negedge clk); check("freeze A", rf_dataw, 32'h1);
        if_insn = '0;
        @(negedge clk); check("freeze B", rf_dataw, 32'h2);
        @(negedge clk); check("freeze C", rf_dataw, 32'h2);
        @(negedge clk); check("freeze tail", rf_dataw, 32'h0);
        issue(addi(19, 17, 16'h0), 32'h2, "no dup write");
        drain();

        // wb_freeze holds the WB result on the bus.
        if_insn = addi(25, 25, 16'h9);
        @(negedge clk); if_insn = '0;
        @(negedge clk); @(negedge clk);
        check("wb before freeze", rf_dataw, 32'h9);
        wb_freeze = 1'b1;
        @(negedge clk); check("wb held", rf_dataw, 32'h9);
        wb_freeze = 1'b0;
        @(negedge clk); check("wb released", rf_dataw, 32'h0);
        issue(addi(26, 25, 16'h0), 32'h9, "wb write once");
        drain();

        // Each flush source kills ID and EX; the first also fights a freeze.
        for (int src = 0; src < 3; src++) begin
            if_insn = addi(27, 27, 16'h5); @(negedge clk);
            if_insn = addi(28, 28, 16'h6); @(negedge clk);
            if_insn = '0;
            except_flushpipe = (src == 0);
            extend_flush     = (src == 1);
            du_hwbkpt        = (src == 2);
            ex_freeze        = (src == 0);
            @(negedge clk);
            except_flushpipe = 0; extend_flush = 0; du_hwbkpt = 0; ex_freeze = 0;
            check("flush wb0", rf_dataw, 32'h0);
            @(negedge clk); check("flush wb1", rf_dataw, 32'h0);
            @(negedge clk); check("flush wb2", rf_dataw, 32'h0);
            issue(addi(29, 27, 16'h0), 32'h0, "flushed r27");
            issue(addi(29, 28, 16'h0), 32'h0, "flushed r28");
            drain();
        end

        // Reset in the middle of a permutation.
        issue(cust5(0, 2, 0, OP_START), 32'h0, "start2");
        issue(cust5(0, 2, 0, OP_END),   32'h0, "end2");
        if_insn = cust5(30, 0, 0, OP_READ);
        repeat (3) @(negedge clk);
        if_insn = '0;
        sb.delete();
        #2 rst = 1'b0;
        #1 check("async reset rf_dataw", rf_dataw, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        issue(addi(1, 0, 16'h0055),      32'h55, "post reset addi");
        issue(cust5(0, 1, 0, OP_START),  32'h0,  "post reset start");
        issue(cust5(30, 0, 0, OP_READ),  32'h55, "not busy after reset");
        issue(cust5(30, 0, 1, OP_READ),  32'h0,  "state cleared");
        issue(addi(31, 2, 16'h0000),     32'h0,  "gpr cleared");
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
